// File: rtl/wb_host_bridge.sv
// Native valid/ready memory port to single-beat classic Wishbone master.
// Optional hung-cycle abort enabled by defining WB_TIMEOUT_EN.
module wb_host_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        abort;
    logic        unused_addr;

    assign unused_addr = ^mem_addr_i[1:0];

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_host_bridge: TIMEOUT_CYCLES out of range 1..65535");
    end

`ifdef WB_TIMEOUT_EN
    localparam logic [15:0] TERM = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    // Count is zero whenever BUS is entered because IDLE keeps it cleared.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE) begin
            cnt_d = 16'd0;
        end else if (state_q == BUS && !wb_ack_i) begin
            cnt_d = cnt_q + 16'd1;
            if (abort) begin
                err_d = 1'b1;
            end
        end
    end

    assign abort = (state_q == BUS) && (cnt_q == TERM);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus_err_o = err_q;
`else
    assign abort     = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    adr_d   = {mem_addr_i[31:2], 2'b00};
                    dat_d   = mem_wdata_i;
                    we_d    = |mem_wstrb_i;
                    sel_d   = (|mem_wstrb_i) ? mem_wstrb_i : 4'hF;
                    cyc_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack takes priority over a coincident terminal count.
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = wb_dat_i;
                    end
                    state_d = DONE;
                end else if (abort) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = ERR_DATA;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed bench for wb_host_bridge with a small SRAM-like Wishbone slave.
// Define WB_TIMEOUT_EN to also exercise the hung-cycle abort.
module tb_wb_host_bridge;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'h0;
    logic        ready;
    logic [31:0] rdata;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic [31:0] sdat = 32'd0;
    logic        ack;
    logic        err;
    logic        hang = 1'b0;
    logic [1:0]  wcnt;
    logic [31:0] mem [16] = '{default: 32'd0};

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_host_bridge #(
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA      (32'hFFFF_FFFF)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .mem_valid_i(valid),
        .mem_addr_i (addr),
        .mem_wdata_i(wdata),
        .mem_wstrb_i(wstrb),
        .mem_ready_o(ready),
        .mem_rdata_o(rdata),
        .wb_cyc_o   (cyc),
        .wb_stb_o   (stb),
        .wb_we_o    (we),
        .wb_sel_o   (sel),
        .wb_adr_o   (adr),
        .wb_dat_o   (dat),
        .wb_dat_i   (sdat),
        .wb_ack_i   (ack),
        .bus_err_o  (err)
    );

    // Slave: write acks 1 cycle after stb, read acks 2 cycles after stb.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack  <= 1'b0;
            wcnt <= 2'd0;
        end else begin
            ack <= 1'b0;
            if (cyc && stb && !ack && !hang) begin
                if (wcnt == (we ? 2'd0 : 2'd1)) begin
                    ack  <= 1'b1;
                    wcnt <= 2'd0;
                    if (we) begin
                        for (int b = 0; b < 4; b++)
                            if (sel[b])
                                mem[adr[5:2]][8*b +: 8] <= dat[8*b +: 8];
                    end else begin
                        sdat <= mem[adr[5:2]];
                    end
                end else begin
                    wcnt <= wcnt + 2'd1;
                end
            end else if (!cyc) begin
                wcnt <= 2'd0;
            end
        end
    end

    task automatic start_req(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        addr  = a;
        wdata = d;
        wstrb = s;
        valid = 1'b1;
    endtask

    // Edges until mem_ready is seen; -1 if it never arrives.
    task automatic wait_ready(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int k;
        #2 rst_n = 1'b0;
        start_req(32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cyc, stb, we, ready, err} !== 5'b0) begin
            bad++;
            $display("FAIL rst_ctrl got=%b want=00000", {cyc, stb, we, ready, err});
        end
        total++;
        if ({sel, adr, dat, rdata} !== 100'd0) begin
            bad++;
            $display("FAIL rst_data got sel=%h adr=%h dat=%h rdata=%h want 0",
                     sel, adr, dat, rdata);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (cyc !== 1'b1) begin
            bad++;
            $display("FAIL rst_release_cyc got=%b want=1", cyc);
        end
        wait_ready(k);
        total++;
        if (k !== 3) begin
            bad++;
            $display("FAIL rst_first_read_lat got=%0d want=3", k);
        end
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_write;
        int k;
        start_req(32'h0000_0014, 32'hA5A5_1234, 4'b0011);
        @(posedge clk);
        #1;
        total++;
        if ({cyc, stb, we, sel} !== 7'b111_0011) begin
            bad++;
            $display("FAIL wr_ctrl got=%b want=1110011", {cyc, stb, we, sel});
        end
        total++;
        if (adr !== 32'h14 || dat !== 32'hA5A5_1234) begin
            bad++;
            $display("FAIL wr_adr_dat got=%h/%h want=00000014/a5a51234", adr, dat);
        end
        wait_ready(k);
        total++;
        if (k !== 2) begin
            bad++;
            $display("FAIL wr_lat got=%0d want=2", k);
        end
        total++;
        if (cyc !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL wr_done_cyc_err got=%b%b want=00", cyc, err);
        end
        valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL wr_ready_pulse got=%b want=0", ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_read;
        int k;
        start_req(32'h0000_0014, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        total++;
        if ({cyc, we, sel} !== 6'b10_1111) begin
            bad++;
            $display("FAIL rd_ctrl got=%b want=101111", {cyc, we, sel});
        end
        wait_ready(k);
        total++;
        if (k !== 3) begin
            bad++;
            $display("FAIL rd_lat got=%0d want=3", k);
        end
        total++;
        if (rdata !== 32'h0000_1234) begin
            bad++;
            $display("FAIL rd_data got=%h want=00001234", rdata);
        end
        valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL rd_ready_pulse got=%b want=0", ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_unaligned_hold;
        int k;
        start_req(32'h0000_0017, 32'h1111_2222, 4'hF);
        @(posedge clk);
        #1;
        total++;
        if (adr !== 32'h0000_0014) begin
            bad++;
            $display("FAIL ua_adr got=%h want=00000014", adr);
        end
        wait_ready(k);
        total++;
        if (k !== 2 || rdata !== 32'h0000_1234) begin
            bad++;
            $display("FAIL ua_lat_rdata got=%0d/%h want=2/00001234", k, rdata);
        end
        @(posedge clk);
        #1;
        total++;
        if (cyc !== 1'b0) begin
            bad++;
            $display("FAIL ua_done_ignores_valid got=%b want=0", cyc);
        end
        valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (cyc !== 1'b0) begin
            bad++;
            $display("FAIL ua_single_cycle got=%b want=0", cyc);
        end
    endtask

    task automatic test_back_to_back;
        int k;
        start_req(32'h0000_0020, 32'hDEAD_BEEF, 4'hF);
        @(posedge clk);
        #1;
        wait_ready(k);
        total++;
        if (k !== 2) begin
            bad++;
            $display("FAIL b2b_first_lat got=%0d want=2", k);
        end
        start_req(32'h0000_0014, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        total++;
        if (cyc !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap got=%b want=0", cyc);
        end
        @(posedge clk);
        #1;
        total++;
        if (cyc !== 1'b1 || adr !== 32'h14 || we !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second got cyc=%b adr=%h we=%b want 1/00000014/0",
                     cyc, adr, we);
        end
        wait_ready(k);
        total++;
        if (k !== 3 || rdata !== 32'h1111_2222) begin
            bad++;
            $display("FAIL b2b_second_rd got=%0d/%h want=3/11112222", k, rdata);
        end
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout;
        int k;
        int held;
        hang = 1'b1;
        start_req(32'h0000_0024, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        held = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (cyc === 1'b1 && ready === 1'b0 && err === 1'b0)
                held++;
        end
        total++;
        if (held !== 3) begin
            bad++;
            $display("FAIL to_hold got=%0d want=3", held);
        end
        @(posedge clk);
        #1;
        total++;
        if ({cyc, ready, err} !== 3'b011) begin
            bad++;
            $display("FAIL to_abort got=%b want=011", {cyc, ready, err});
        end
        total++;
        if (rdata !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL to_errdata got=%h want=ffffffff", rdata);
        end
        valid = 1'b0;
        hang  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start_req(32'h0000_0028, 32'h5, 4'hF);
        @(posedge clk);
        #1;
        wait_ready(k);
        total++;
        if (k !== 2 || err !== 1'b1) begin
            bad++;
            $display("FAIL to_sticky got lat=%0d err=%b want 2/1", k, err);
        end
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_async_reset;
        int k;
        int quiet;
        hang = 1'b1;
        start_req(32'h0000_0020, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        total++;
        if (cyc !== 1'b1) begin
            bad++;
            $display("FAIL ar_cyc_up got=%b want=1", cyc);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cyc, stb, ready, err} !== 4'b0) begin
            bad++;
            $display("FAIL ar_immediate got=%b want=0000", {cyc, stb, ready, err});
        end
        quiet = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b0 && cyc === 1'b0)
                quiet++;
        end
        total++;
        if (quiet !== 2) begin
            bad++;
            $display("FAIL ar_no_ready got=%0d want=2", quiet);
        end
        hang  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wait_ready(k);
        total++;
        if (k !== 3 || rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL ar_recover got=%0d/%h want=3/deadbeef", k, rdata);
        end
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_unaligned_hold();
        test_back_to_back();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
